// File: rtl/led_display_ctrl_pkg.sv
// Shared types, 7-segment glyphs and helpers for the LED / timer display controller.
// Segment vectors are {a,b,c,d,e,f,g} with a in the MSB, active-low (0 = segment lit).
package led_display_ctrl_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_LOAD  = 2'd1,
    CONV_SHIFT = 2'd2,
    CONV_DONE  = 2'd3
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h01;
  localparam logic [6:0] SEG_1     = 7'h4F;
  localparam logic [6:0] SEG_2     = 7'h12;
  localparam logic [6:0] SEG_3     = 7'h06;
  localparam logic [6:0] SEG_4     = 7'h4C;
  localparam logic [6:0] SEG_5     = 7'h24;
  localparam logic [6:0] SEG_6     = 7'h20;
  localparam logic [6:0] SEG_7     = 7'h0F;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h04;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h60;
  localparam logic [6:0] SEG_C     = 7'h31;
  localparam logic [6:0] SEG_D     = 7'h42;
  localparam logic [6:0] SEG_E     = 7'h30;
  localparam logic [6:0] SEG_F     = 7'h38;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0:    hex_glyph = SEG_0;
      4'h1:    hex_glyph = SEG_1;
      4'h2:    hex_glyph = SEG_2;
      4'h3:    hex_glyph = SEG_3;
      4'h4:    hex_glyph = SEG_4;
      4'h5:    hex_glyph = SEG_5;
      4'h6:    hex_glyph = SEG_6;
      4'h7:    hex_glyph = SEG_7;
      4'h8:    hex_glyph = SEG_8;
      4'h9:    hex_glyph = SEG_9;
      4'hA:    hex_glyph = SEG_A;
      4'hB:    hex_glyph = SEG_B;
      4'hC:    hex_glyph = SEG_C;
      4'hD:    hex_glyph = SEG_D;
      4'hE:    hex_glyph = SEG_E;
      default: hex_glyph = SEG_F;
    endcase
  endfunction

  // Elaboration-time 10^n, used for the display saturation threshold.
  function automatic longint unsigned pow10(input int n);
    pow10 = 1;
    for (int i = 0; i < n; i++) pow10 = pow10 * 10;
  endfunction

endpackage

// File: rtl/led_display_ctrl_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter: one shift-add-3 step per cycle,
// keeping only N_DIGITS digits and saturating to all nines when the value does not fit.
module bin2bcd_seq
  import led_display_ctrl_pkg::*;
#(
  parameter int TIMER_W  = 16,
  parameter int N_DIGITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [TIMER_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [N_DIGITS*4-1:0]   bcd,
  output logic [TIMER_W-1:0]      captured
);

  localparam int CNT_W = $clog2(TIMER_W + 1);
  localparam longint unsigned SAT_LIMIT = pow10(N_DIGITS);

  conv_state_t             state;
  logic [TIMER_W-1:0]      shadow;
  logic [TIMER_W-1:0]      shreg;
  logic [N_DIGITS*4-1:0]   bcd_q;
  logic [N_DIGITS*4-1:0]   adj;
  logic [CNT_W-1:0]        cnt;

  // NOTE: combinational blocks assign every output up front so no path leaves a latch.
  always_comb begin
    adj = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
  end

  // Dropping carries out of the top digit leaves value mod 10^N_DIGITS; overflow is
  // handled by saturation instead of wider BCD storage.
  assign bcd      = (64'(shadow) >= SAT_LIMIT) ? {N_DIGITS{4'd9}} : bcd_q;
  assign done     = (state == CONV_DONE);
  assign captured = shadow;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CONV_IDLE;
      shadow <= '0;
      shreg  <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          if (start) begin
            state <= CONV_LOAD;
            busy  <= 1'b1;
          end
        end
        CONV_LOAD: begin
          shadow <= bin;
          shreg  <= bin;
          bcd_q  <= '0;
          cnt    <= '0;
          state  <= CONV_SHIFT;
        end
        CONV_SHIFT: begin
          bcd_q <= {adj[N_DIGITS*4-2:0], shreg[TIMER_W-1]};
          shreg <= shreg << 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(TIMER_W - 1)) state <= CONV_DONE;
        end
        default: begin
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/led_display_ctrl.sv
// Status LED pattern generator plus registered 7-segment drivers for the countdown timer
// (via the sequential BCD converter) and a single hex value digit.
module led_display_ctrl
  import led_display_ctrl_pkg::*;
#(
  parameter int N_LEDS       = 10,
  parameter int N_DIGITS     = 2,
  parameter int TIMER_W      = 16,
  parameter int BLINK_CYCLES = 25_000_000,
  parameter int CHASE_CYCLES = 5_000_000,
  parameter int LZ_BLANK     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  fsm_state_t                   system_state,
  input  logic [TIMER_W-1:0]           timer,
  input  logic [3:0]                   current_value,
  output logic [N_LEDS-1:0]            led,
  output logic [N_DIGITS-1:0][6:0]     hex_time,
  output logic [6:0]                   hex_val,
  output logic                         disp_busy
);

  localparam int MAX_CYC = (BLINK_CYCLES > CHASE_CYCLES) ? BLINK_CYCLES : CHASE_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  fsm_state_t                 prev_state;
  logic [CNT_W-1:0]           cnt;

  logic                       conv_start;
  logic                       conv_done;
  logic [N_DIGITS*4-1:0]      conv_bcd;
  logic [TIMER_W-1:0]         conv_captured;
  logic [N_DIGITS-1:0][6:0]   new_glyphs;
  logic [N_DIGITS-1:0][6:0]   shown_q;
  logic                       shown_valid;
  logic                       leading;

  // ---------------- status LEDs ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led        <= '0;
      cnt        <= '0;
      prev_state <= STATE_IDLE;
    end else begin
      prev_state <= system_state;
      if (system_state != prev_state) begin
        cnt <= '0;
        case (system_state)
          STATE_IDLE:    led <= '0;
          STATE_TRIGGER: led <= N_LEDS'(1);
          default:       led <= '1;
        endcase
      end else begin
        case (system_state)
          STATE_TRIGGER: begin
            if (cnt == CNT_W'(CHASE_CYCLES - 1)) begin
              cnt <= '0;
              led <= (led << 1) | (led >> (N_LEDS - 1));
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STATE_ALERT: begin
            if (cnt == CNT_W'(BLINK_CYCLES - 1)) begin
              cnt <= '0;
              led <= ~led;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: cnt <= '0;
        endcase
      end
    end
  end

  // ---------------- timer conversion ----------------
  assign conv_start = (timer != conv_captured);

  bin2bcd_seq #(
    .TIMER_W  (TIMER_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (conv_start),
    .bin      (timer),
    .busy     (disp_busy),
    .done     (conv_done),
    .bcd      (conv_bcd),
    .captured (conv_captured)
  );

  // Scan from the most significant digit; digit 0 always shows a numeral.
  always_comb begin
    new_glyphs = '0;
    leading    = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (LZ_BLANK != 0 && i != 0 && leading && conv_bcd[i*4 +: 4] == 4'd0) begin
        new_glyphs[i] = SEG_BLANK;
      end else begin
        new_glyphs[i] = hex_glyph(conv_bcd[i*4 +: 4]);
        leading       = 1'b0;
      end
    end
  end

  // shown_q keeps the last conversion so leaving STATE_IDLE restores it without reconverting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_time    <= {N_DIGITS{SEG_BLANK}};
      shown_q     <= {N_DIGITS{SEG_BLANK}};
      shown_valid <= 1'b0;
      hex_val     <= SEG_BLANK;
    end else begin
      hex_val <= hex_glyph(current_value);
      if (conv_done) begin
        shown_q     <= new_glyphs;
        shown_valid <= 1'b1;
      end
      if (system_state == STATE_IDLE) hex_time <= {N_DIGITS{SEG_BLANK}};
      else if (conv_done)             hex_time <= new_glyphs;
      else if (shown_valid)           hex_time <= shown_q;
      else                            hex_time <= {N_DIGITS{SEG_BLANK}};
    end
  end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Directed bench for led_display_ctrl: expected timer displays are queued at stimulus time
// and checked by a monitor whenever disp_busy falls; LED/hex_val/reset are checked inline.
module tb_led_display_ctrl;
  import led_display_ctrl_pkg::*;

  localparam int N_LEDS = 10;
  localparam int N_DIG  = 2;
  localparam int TW     = 16;

  localparam logic [6:0] G0 = 7'h01, G1 = 7'h4F, G2 = 7'h12, G3 = 7'h06, G4 = 7'h4C;
  localparam logic [6:0] G5 = 7'h24, G7 = 7'h0F, G9 = 7'h04, GA = 7'h08, GB = 7'h60;
  localparam logic [6:0] BL = 7'h7F;

  logic                      clk = 1'b0;
  logic                      rst_n;
  fsm_state_t                system_state;
  logic [TW-1:0]             timer;
  logic [3:0]                current_value;
  logic [N_LEDS-1:0]         led;
  logic [N_DIG-1:0][6:0]     hex_time;
  logic [6:0]                hex_val;
  logic                      disp_busy;

  int n_cmp = 0;
  int n_err = 0;
  logic [13:0] sb[$];

  led_display_ctrl #(
    .N_LEDS       (N_LEDS),
    .N_DIGITS     (N_DIG),
    .TIMER_W      (TW),
    .BLINK_CYCLES (4),
    .CHASE_CYCLES (3),
    .LZ_BLANK     (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .system_state  (system_state),
    .timer         (timer),
    .current_value (current_value),
    .led           (led),
    .hex_time      (hex_time),
    .hex_val       (hex_val),
    .disp_busy     (disp_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard monitor: a falling disp_busy means hex_time was just written.
  initial begin : monitor
    logic        prev_busy;
    logic [13:0] exp;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
      end else begin
        if (prev_busy && !disp_busy) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL conv_unexpected: got %h expected no conversion", hex_time);
          end else begin
            exp = sb.pop_front();
            check("conv_result", 32'(hex_time), 32'(exp));
          end
        end
        prev_busy = disp_busy;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n         = 1'b0;
    timer         = '0;
    current_value = 4'h3;
    system_state  = STATE_SET;
    wait_neg(3);
    check("rst_led", 32'(led), 32'h0);
    check("rst_hex_time", 32'(hex_time), 32'h3FFF);
    check("rst_hex_val", 32'(hex_val), 32'(BL));
    check("rst_busy", 32'(disp_busy), 32'h0);
    rst_n = 1'b1;

    // 42 with exact latency: not visible after 18 edges, visible after 19.
    @(negedge clk);
    timer = 16'd42;
    sb.push_back({G4, G2});
    wait_neg(18);
    check("lat42_pre_hex", 32'(hex_time), 32'h3FFF);
    check("lat42_pre_busy", 32'(disp_busy), 32'h1);
    wait_neg(1);
    check("lat42_hex", 32'(hex_time), 32'({G4, G2}));
    check("lat42_busy", 32'(disp_busy), 32'h0);
    check("set_led", 32'(led), 32'h3FF);

    // Leading-zero blanking and saturation.
    timer = 16'd7;
    sb.push_back({BL, G7});
    wait_neg(25);
    timer = 16'd250;
    sb.push_back({G9, G9});
    wait_neg(25);

    // Change mid-conversion: 15 is shown first, then 30, nothing in between.
    timer = 16'd15;
    sb.push_back({G1, G5});
    wait_neg(5);
    timer = 16'd30;
    sb.push_back({G3, G0});
    wait_neg(45);

    current_value = 4'hA;
    wait_neg(1);
    check("hex_val_A", 32'(hex_val), 32'(GA));

    // IDLE blanks the display but conversion continues in the background.
    system_state = STATE_IDLE;
    timer        = 16'd55;
    sb.push_back({BL, BL});
    wait_neg(1);
    check("idle_hex_blank", 32'(hex_time), 32'h3FFF);
    check("idle_led", 32'(led), 32'h0);
    wait_neg(25);
    system_state = STATE_SET;
    wait_neg(1);
    check("set_restores_55", 32'(hex_time), 32'({G5, G5}));
    check("set_led_again", 32'(led), 32'h3FF);

    // ALERT blink: lit 4 cycles, dark 4 cycles.
    system_state = STATE_ALERT;
    for (int k = 0; k < 12; k++) begin
      wait_neg(1);
      check($sformatf("alert_led_%0d", k), 32'(led), ((k / 4) % 2 == 0) ? 32'h3FF : 32'h0);
    end
    // TRIGGER chase: restarts at bit 0, one step per 3 cycles, wraps after bit 9.
    system_state = STATE_TRIGGER;
    for (int k = 0; k < 33; k++) begin
      wait_neg(1);
      check($sformatf("chase_led_%0d", k), 32'(led), 32'h1 << ((k / 3) % 10));
    end
    system_state = STATE_SET;
    wait_neg(2);

    // Reset mid-SHIFT aborts; the same timer value then starts a fresh conversion.
    timer = 16'd99;
    sb.push_back({G9, G9});
    repeat (5) @(posedge clk);
    #2;
    rst_n         = 1'b0;
    current_value = 4'hB;
    sb.delete();
    #1;
    check("midrst_hex_time", 32'(hex_time), 32'h3FFF);
    check("midrst_hex_val", 32'(hex_val), 32'(BL));
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_busy", 32'(disp_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back({G9, G9});
    wait_neg(1);
    check("hex_val_b", 32'(hex_val), 32'(GB));
    wait_neg(25);

    // After reset, timer 0 stays blank until a real conversion shows "0".
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    timer = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_neg(25);
    check("zero_after_rst_blank", 32'(hex_time), 32'h3FFF);
    timer = 16'd5;
    sb.push_back({BL, G5});
    wait_neg(25);
    timer = 16'd0;
    sb.push_back({BL, G0});
    wait_neg(25);

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
